// File: rtl/note_sequencer.sv
// Note-level controller: queues note entries and plays them one at a time against the sample strobe.
// Optional macro NOTE_SEQ_GAP_EN inserts one silent sample tick between back-to-back notes.
module note_sequencer #(
  parameter int DEPTH = 16,
  parameter int DUR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freq,
  input  logic                     enable,
  input  logic                     stop,
  input  logic                     wr_en,
  input  logic [2:0]               wr_gen,
  input  logic [7:0]               wr_sound,
  input  logic [DUR_W-1:0]         wr_dur,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [7:0]               soundType,
  output logic [2:0]               genType,
  output logic                     startT,
  output logic                     busy,
  output logic                     note_done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int ENT_W = 3 + 8 + DUR_W;

`ifdef NOTE_SEQ_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;
`endif

  state_t           state;
  logic [DUR_W-1:0] cnt;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [ENT_W-1:0] head;
  logic [2:0]       head_gen;
  logic [7:0]       head_sound;
  logic [DUR_W-1:0] head_dur;

  logic push;
  logic pop;
  logic ovf_evt;
  logic note_end;

  // A zero-length entry still has to sound for one sample tick.
  function automatic logic [DUR_W-1:0] sat_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign head       = mem[rd_ptr];
  assign head_gen   = head[ENT_W-1 -: 3];
  assign head_sound = head[DUR_W+7 -: 8];
  assign head_dur   = head[DUR_W-1:0];

  // full is the pre-pop value, so a push at full is always dropped; stop swallows pushes silently.
  assign push     = wr_en && !full && !stop;
  assign ovf_evt  = wr_en && full && !stop;
  assign note_end = (state == PLAY) && freq && (cnt == DUR_W'(1));
  assign note_done = note_end && !stop && !rst;

  always_comb begin
    pop = 1'b0;
    if (!stop) begin
      case (state)
        IDLE: pop = enable && !empty;
`ifdef NOTE_SEQ_GAP_EN
        GAP:  pop = freq && !empty;
`else
        PLAY: pop = note_end && enable && !empty;
`endif
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_gen, wr_sound, wr_dur};
  end

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (ovf_evt) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      soundType <= 8'h00;
      genType   <= 3'd0;
      startT    <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      startT <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        soundType <= 8'h00;
        startT    <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              soundType <= head_sound;
              genType   <= head_gen;
              startT    <= 1'b1;
              busy      <= 1'b1;
              cnt       <= sat_dur(head_dur);
              state     <= PLAY;
            end
          end
          PLAY: begin
            if (note_end) begin
              if (enable && !empty) begin
`ifdef NOTE_SEQ_GAP_EN
                soundType <= 8'h00;
                startT    <= 1'b1;
                state     <= GAP;
`else
                soundType <= head_sound;
                genType   <= head_gen;
                startT    <= 1'b1;
                cnt       <= sat_dur(head_dur);
`endif
              end else begin
                soundType <= 8'h00;
                startT    <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end
            end else if (freq) begin
              cnt <= cnt - DUR_W'(1);
            end
          end
`ifdef NOTE_SEQ_GAP_EN
          GAP: begin
            if (freq) begin
              if (pop) begin
                soundType <= head_sound;
                genType   <= head_gen;
                startT    <= 1'b1;
                cnt       <= sat_dur(head_dur);
                state     <= PLAY;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: table of single notes plus hand-written multi-cycle sequences.
module tb_note_sequencer;

  logic        clk;
  logic        rst;
  logic        freq;
  logic        enable;
  logic        stop;
  logic        wr_en;
  logic [2:0]  wr_gen;
  logic [7:0]  wr_sound;
  logic [15:0] wr_dur;
  logic        full;
  logic        empty;
  logic [4:0]  level;
  logic        overflow;
  logic        clr_ovf;
  logic [7:0]  soundType;
  logic [2:0]  genType;
  logic        startT;
  logic        busy;
  logic        note_done;

  int n_cmp  = 0;
  int n_fail = 0;

  note_sequencer #(.DEPTH(16), .DUR_W(16)) dut (
    .clk(clk), .rst(rst), .freq(freq), .enable(enable), .stop(stop),
    .wr_en(wr_en), .wr_gen(wr_gen), .wr_sound(wr_sound), .wr_dur(wr_dur),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .clr_ovf(clr_ovf), .soundType(soundType), .genType(genType),
    .startT(startT), .busy(busy), .note_done(note_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  gen;
    logic [7:0]  sound;
    logic [15:0] dur;
    int          ticks;
  } vec_t;

  vec_t vecs [4];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] g, input logic [7:0] s, input logic [15:0] d);
    wr_en = 1'b1; wr_gen = g; wr_sound = s; wr_dur = d;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq [$];
    logic [7:0] exp_seq [$];
    int         nd;
    int         strobes;
    logic       fq;

    vecs[0] = '{gen: 3'd1, sound: 8'hDA, dur: 16'd3, ticks: 3};
    vecs[1] = '{gen: 3'd0, sound: 8'h4B, dur: 16'd1, ticks: 1};
    vecs[2] = '{gen: 3'd5, sound: 8'hFF, dur: 16'd0, ticks: 1};
    vecs[3] = '{gen: 3'd3, sound: 8'h91, dur: 16'd2, ticks: 2};

    rst = 1'b1; freq = 1'b0; enable = 1'b0; stop = 1'b0; wr_en = 1'b0;
    wr_gen = 3'd0; wr_sound = 8'h00; wr_dur = 16'd0; clr_ovf = 1'b0;
    cyc(); cyc();
    chk("reset_outputs", {soundType, genType, startT, busy, note_done}, 32'h0);
    chk("reset_fifo", {level, empty, full, overflow}, {5'd0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    cyc();

    // Single notes from the table
    for (int v = 0; v < 4; v++) begin
      push(vecs[v].gen, vecs[v].sound, vecs[v].dur);
      enable = 1'b1;
      cyc();
      enable = 1'b0;
      chk("note_start", {startT, busy, soundType, genType}, {1'b1, 1'b1, vecs[v].sound, vecs[v].gen});
      for (int k = 1; k <= vecs[v].ticks; k++) begin
        cyc();
        freq = 1'b1;
        #1;
        chk("note_done", note_done, (k == vecs[v].ticks));
        cyc();
        freq = 1'b0;
        if (k < vecs[v].ticks) chk("mid_note", {startT, busy}, 2'b01);
      end
      chk("note_end", {startT, busy, soundType, genType}, {1'b1, 1'b0, 8'h00, vecs[v].gen});
      cyc();
      chk("after_end", {startT, busy}, 2'b00);
    end

    // Back-to-back: dur 2 then dur 1
    push(3'd2, 8'h9A, 16'd2);
    push(3'd3, 8'h5C, 16'd1);
    enable = 1'b1;
    nd = 0; strobes = 0;
    for (int i = 0; i < 40; i++) begin
      freq = (i % 4 == 3);
      fq = freq;
      #1;
      if (note_done) nd++;
      cyc();
      freq = 1'b0;
      if (fq) strobes++;
      if (startT) seq.push_back(soundType);
`ifndef NOTE_SEQ_GAP_EN
      if (fq && strobes == 2) chk("gapless_load", {startT, soundType}, {1'b1, 8'h5C});
`endif
    end
    enable = 1'b0;
`ifdef NOTE_SEQ_GAP_EN
    exp_seq = '{8'h9A, 8'h00, 8'h5C, 8'h00};
`else
    exp_seq = '{8'h9A, 8'h5C, 8'h00};
`endif
    chk("b2b_pulses", seq.size(), exp_seq.size());
    for (int j = 0; j < exp_seq.size() && j < seq.size(); j++)
      chk("b2b_sound", seq[j], exp_seq[j]);
    chk("b2b_note_done", nd, 2);
    chk("b2b_idle", {busy, level}, 6'd0);

    // FIFO boundary, with enable low
    for (int i = 0; i < 16; i++) push(3'(i % 6), 8'(8'h40 + i), 16'd1);
    chk("full_16", {full, level, overflow}, {1'b1, 5'd16, 1'b0});
    push(3'd0, 8'h77, 16'd1);
    chk("overflow_17", {full, level, overflow}, {1'b1, 5'd16, 1'b1});
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 1'b0);
    clr_ovf = 1'b1;
    push(3'd0, 8'h78, 16'd1);
    clr_ovf = 1'b0;
    chk("ovf_beats_clr", {overflow, level}, {1'b1, 5'd16});
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    enable = 1'b1;
    cyc();
    chk("pop_from_full", {level, startT, soundType}, {5'd15, 1'b1, 8'h40});
    wr_en = 1'b1; wr_gen = 3'd1; wr_sound = 8'hE1; wr_dur = 16'd1; freq = 1'b1;
    cyc();
    wr_en = 1'b0; freq = 1'b0;
`ifdef NOTE_SEQ_GAP_EN
    chk("push_at_end", level, 5'd16);
`else
    chk("push_pop_same", {level, startT, soundType}, {5'd15, 1'b1, 8'h41});
`endif

    // Stop with a pending note end and a push in the same cycle
    stop = 1'b1; wr_en = 1'b1; freq = 1'b1;
    #1;
    chk("stop_no_done", note_done, 1'b0);
    cyc();
    stop = 1'b0; wr_en = 1'b0; freq = 1'b0;
    chk("stop_flush", {level, empty, overflow}, {5'd0, 1'b1, 1'b0});
    chk("stop_silence", {startT, busy, soundType}, {1'b1, 1'b0, 8'h00});
    cyc();
    chk("stop_idle", {startT, busy}, 2'b00);
    enable = 1'b0;

    // Enable drop mid-note, then a zero-duration entry
    push(3'd4, 8'hC3, 16'd2);
    push(3'd2, 8'h2D, 16'd0);
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    chk("en_note1", {startT, soundType, level}, {1'b1, 8'hC3, 5'd1});
    for (int k = 1; k <= 2; k++) begin
      cyc();
      freq = 1'b1;
      #1;
      chk("en_done1", note_done, (k == 2));
      cyc();
      freq = 1'b0;
    end
    chk("en_halt", {startT, busy, soundType, level}, {1'b1, 1'b0, 8'h00, 5'd1});
    freq = 1'b1;
    cyc();
    freq = 1'b0;
    cyc();
    chk("en_held", {startT, busy, level}, {1'b0, 1'b0, 5'd1});
    enable = 1'b1;
    cyc();
    chk("en_note2", {startT, busy, soundType, genType, level}, {1'b1, 1'b1, 8'h2D, 3'd2, 5'd0});
    freq = 1'b1;
    #1;
    chk("zero_dur_done", note_done, 1'b1);
    cyc();
    freq = 1'b0;
    chk("zero_dur_end", {startT, busy, soundType}, {1'b1, 1'b0, 8'h00});

    // Reset mid-note
    push(3'd4, 8'hB6, 16'd5);
    push(3'd1, 8'h11, 16'd5);
    cyc();
    chk("rst_pre_play", {busy, soundType, genType}, {1'b1, 8'hB6, 3'd4});
    rst = 1'b1; freq = 1'b1;
    #1;
    chk("rst_no_done", note_done, 1'b0);
    cyc(); cyc();
    chk("rst_mid_outputs", {soundType, genType, startT, busy, note_done}, 32'h0);
    chk("rst_mid_fifo", {level, empty, full, overflow}, {5'd0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0; freq = 1'b0;
    cyc();
    chk("rst_then_idle", {startT, busy}, 2'b00);
    enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
